exception_ctrl: RTL
===================

# exception_ctrl

Exception/interrupt arbiter in the MEM stage, directly upstream of the CP0 register file. Each cycle it collects the per-instruction exception flags carried down the pipeline, synchronises the external interrupt lines and applies the CP0 interrupt mask. It prioritises these into a single event and drives CP0's `en`/`except_type`/`is_in_delayslot`/`current_inst_addr`/`badvaddr_i` inputs for exactly one cycle. In that same cycle it issues the pipeline flush and the redirect PC; ERET is handled the same way.

## Interface
- `EXC_VECTOR`, 32'hBFC00380: redirect PC for every exception and interrupt.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low (asserted at 0).
- `ext_int` in 6: asynchronous hardware interrupt lines, active-high.
- `timer_interrupt` in 1: from CP0; ORed into hardware line 5 (IP7).
- `cp0_status`, `cp0_cause`, `cp0_epc` in 32 each: current CP0 register values.
- `mem_valid` in 1: MEM stage holds a real (non-bubble) instruction.
- `mem_stall` in 1: MEM stage frozen this cycle.
- `mem_pc` in 32: PC of the MEM instruction.
- `mem_in_delayslot` in 1: the MEM instruction sits in a branch delay slot.
- `mem_flags` in 7: {fetch_adel, ri, syscall, brk, ov, data_adel, data_ades}, bit 6..0.
- `mem_fetch_addr`, `mem_data_addr` in 32 each: faulting addresses for fetch and data AdE.
- `mem_eret` in 1: the MEM instruction is ERET.
- `except_now` out 1: combinational; an event is accepted this cycle. Suppresses the data-SRAM write of the MEM instruction.
- `cp0_en` out 1: registered; CP0 update strobe.
- `except_type` out 5: registered; `EXC_CODE_*`, 5'b11110 for ERET, 5'b11111 when idle.
- `is_in_delayslot`, `current_inst_addr`, `badvaddr_i` out 1/32/32: registered CP0 inputs.
- `flush` out 1: registered; clears IF/ID/EX/MEM/WB pipeline registers.
- `new_pc` out 32: registered; fetch redirect target, valid while `flush`=1.
- `exc_count` out 16: saturating count of accepted events (debug).

## Operation
- Interrupt sync: two-flop synchroniser per `ext_int` bit. `ip[7:2] = sync | {timer_interrupt,5'b0}`, `ip[1:0] = cp0_cause[9:8]`.
- `int_pend = |(ip & cp0_status[15:8]) & cp0_status[0] & ~cp0_status[1]`.
- Accept condition: state IDLE, `mem_valid`=1, `mem_stall`=0, and any of `int_pend`, a set bit in `mem_flags`, or `mem_eret`.
- Priority, high to low: INT(00000), fetch AdEL(00100), RI(01010), SYS(01000), BP(01001), OV(01100), data AdEL(00100), data AdES(00101), ERET(11110).
- badvaddr_i: `mem_fetch_addr` for fetch AdEL, `mem_data_addr` for data AdEL/AdES, otherwise 0.
- new_pc: `EXC_VECTOR` for exceptions and interrupts; `cp0_epc` sampled at acceptance for ERET.
- FSM IDLE: on accept, register all outputs and set `cp0_en`=1 and `flush`=1; go to FLUSH.
- FSM FLUSH (exactly 1 cycle): outputs stay as registered and MEM inputs are ignored. Next edge: clear `cp0_en` and `flush`, set `except_type` to 11111, go to IDLE.
- `exc_count` increments on each accept and saturates at 16'hFFFF.

## Timing
- Reset (async, `rst`=0): `cp0_en`=0, `flush`=0, `except_type`=5'b11111, `is_in_delayslot`=0, `current_inst_addr`=0, `badvaddr_i`=0, `new_pc`=0, `exc_count`=0, synchronisers=0, state IDLE. Reset mid-FLUSH aborts the flush immediately.
- Event in MEM during cycle N: `except_now`=1 in cycle N. `cp0_en`/`flush`/`new_pc` are high in cycle N+1. CP0 commits at the N+1→N+2 edge. First redirected fetch is in cycle N+2.
- Interrupt latency: `ext_int` edge to visibility in `int_pend` is 2 clocks, plus waiting for the next valid, unstalled MEM instruction.
- A `mem_stall` during IDLE defers acceptance, with no loss of the event. `mem_stall` during FLUSH has no effect.
- Back-to-back: the earliest next accept is cycle N+2, when CP0 EXL is already set, so interrupts are masked.
- Simultaneous events: the single highest-priority event wins. Interrupt beats ERET. Any exception flag beats ERET.

## Test plan
- Reset: hold `rst`=0 with arbitrary inputs -> all outputs at reset values, `except_type`=11111.
- Syscall: `mem_pc`=32'hBFC00100, `mem_flags`=7'b0010000, no delay slot -> cycle N+1: `cp0_en`=1, `except_type`=01000, `current_inst_addr`=BFC00100, `new_pc`=BFC00380, `flush`=1 for 1 cycle; `exc_count`=1.
- Priority: ri+ov+data_ades together in a delay slot -> `except_type`=01010, `is_in_delayslot`=1, `badvaddr_i`=0. Data AdES alone with `mem_data_addr`=32'h80000003 -> 00101, `badvaddr_i`=80000003.
- Interrupt: status=32'h0000_0401, pulse `ext_int[0]` -> accepted 2 clocks later on next valid MEM instruction, `except_type`=00000. With status[1]=1 -> no accept.
- ERET: `mem_eret`=1, `cp0_epc`=32'hBFC00200 -> `except_type`=11110, `new_pc`=BFC00200, `flush`=1.
- Stall/reset: event with `mem_stall`=1 for 3 cycles -> no `except_now` until stall drops, then normal sequence. Assert `rst`=0 during FLUSH -> `flush`/`cp0_en` drop without waiting for an edge.

Source files
------------

// File: rtl/exception_ctrl_if.sv
// MEM-stage side of the exception arbiter: the instruction's exception
// flags, addresses and ERET marker flowing down the pipeline, plus the
// combinational accept strobe returned to the MEM stage.
interface exception_ctrl_if;
    logic        mem_valid;
    logic        mem_stall;
    logic [31:0] mem_pc;
    logic        mem_in_delayslot;
    logic [6:0]  mem_flags;       // {fetch_adel, ri, syscall, brk, ov, data_adel, data_ades}
    logic [31:0] mem_fetch_addr;
    logic [31:0] mem_data_addr;
    logic        mem_eret;
    logic        except_now;

    // Pipeline side: presents the MEM instruction, observes the accept strobe
    modport master (
        output mem_valid, mem_stall, mem_pc, mem_in_delayslot, mem_flags,
               mem_fetch_addr, mem_data_addr, mem_eret,
        input  except_now
    );

    // Arbiter side
    modport slave (
        input  mem_valid, mem_stall, mem_pc, mem_in_delayslot, mem_flags,
               mem_fetch_addr, mem_data_addr, mem_eret,
        output except_now
    );
endinterface

// File: rtl/exception_ctrl.sv
// Exception/interrupt arbiter in the MEM stage. Synchronises the external
// interrupt lines, masks them against CP0 Status, picks the single
// highest-priority event, and presents a one-cycle CP0 update together with
// the pipeline flush and redirect PC.
module exception_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           ext_int,
    input  logic                 timer_interrupt,
    input  logic [31:0]          cp0_status,
    input  logic [31:0]          cp0_cause,
    input  logic [31:0]          cp0_epc,
    exception_ctrl_if.slave      mem,
    output logic                 cp0_en,
    output logic [4:0]           except_type,
    output logic                 is_in_delayslot,
    output logic [31:0]          current_inst_addr,
    output logic [31:0]          badvaddr_i,
    output logic                 flush,
    output logic [31:0]          new_pc,
    output logic [15:0]          exc_count
);
    localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;
    localparam logic [4:0]  TYPE_IDLE  = 5'b11111;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [5:0]  sync1_q, sync2_q;
    logic        cp0_en_q, cp0_en_d;
    logic [4:0]  except_type_q, except_type_d;
    logic        ds_q, ds_d;
    logic [31:0] cia_q, cia_d;
    logic [31:0] bad_q, bad_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [15:0] exc_count_q, exc_count_d;

    logic [7:0]  ip_s;
    logic        int_pend_s;
    logic        accept_s;
    logic [4:0]  ev_type_s;
    logic [31:0] ev_bad_s;
    logic [31:0] ev_pc_s;
    logic        unused_cp0_bits_s;

    assign unused_cp0_bits_s = ^{cp0_status[31:16], cp0_status[7:2],
                                 cp0_cause[31:10], cp0_cause[7:0]};

    // Two-flop synchroniser for the asynchronous interrupt lines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 6'd0;
            sync2_q <= 6'd0;
        end else begin
            sync1_q <= ext_int;
            sync2_q <= sync1_q;
        end
    end

    // Timer is already in this clock domain, so it joins after the synchroniser
    assign ip_s       = {sync2_q | {timer_interrupt, 5'b00000}, cp0_cause[9:8]};
    assign int_pend_s = (|(ip_s & cp0_status[15:8])) & cp0_status[0] & ~cp0_status[1];

    assign accept_s = (state_q == ST_IDLE) & mem.mem_valid & ~mem.mem_stall &
                      (int_pend_s | (|mem.mem_flags) | mem.mem_eret);
    assign mem.except_now = accept_s;

    // Priority encoder: interrupt, then instruction exceptions in pipeline order, then ERET
    always_comb begin
        ev_type_s = TYPE_IDLE;
        ev_bad_s  = 32'h0000_0000;
        ev_pc_s   = EXC_VECTOR;
        if (int_pend_s) begin
            ev_type_s = 5'b00000;
        end else if (mem.mem_flags[6]) begin
            ev_type_s = 5'b00100;
            ev_bad_s  = mem.mem_fetch_addr;
        end else if (mem.mem_flags[5]) begin
            ev_type_s = 5'b01010;
        end else if (mem.mem_flags[4]) begin
            ev_type_s = 5'b01000;
        end else if (mem.mem_flags[3]) begin
            ev_type_s = 5'b01001;
        end else if (mem.mem_flags[2]) begin
            ev_type_s = 5'b01100;
        end else if (mem.mem_flags[1]) begin
            ev_type_s = 5'b00100;
            ev_bad_s  = mem.mem_data_addr;
        end else if (mem.mem_flags[0]) begin
            ev_type_s = 5'b00101;
            ev_bad_s  = mem.mem_data_addr;
        end else if (mem.mem_eret) begin
            ev_type_s = 5'b11110;
            ev_pc_s   = cp0_epc;
        end else begin
            ev_type_s = TYPE_IDLE;
        end
    end

    // Next-state and registered-output logic: capture on accept, release after one flush cycle
    always_comb begin
        state_d       = state_q;
        cp0_en_d      = cp0_en_q;
        except_type_d = except_type_q;
        ds_d          = ds_q;
        cia_d         = cia_q;
        bad_d         = bad_q;
        flush_d       = flush_q;
        new_pc_d      = new_pc_q;
        exc_count_d   = exc_count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d       = ST_FLUSH;
                    cp0_en_d      = 1'b1;
                    flush_d       = 1'b1;
                    except_type_d = ev_type_s;
                    ds_d          = mem.mem_in_delayslot;
                    cia_d         = mem.mem_pc;
                    bad_d         = ev_bad_s;
                    new_pc_d      = ev_pc_s;
                    if (exc_count_q != 16'hFFFF) begin
                        exc_count_d = exc_count_q + 16'd1;
                    end else begin
                        exc_count_d = exc_count_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                state_d       = ST_IDLE;
                cp0_en_d      = 1'b0;
                flush_d       = 1'b0;
                except_type_d = TYPE_IDLE;
            end
            default: begin
                state_d       = ST_IDLE;
                cp0_en_d      = 1'b0;
                flush_d       = 1'b0;
                except_type_d = TYPE_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any flush in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cp0_en_q      <= 1'b0;
            except_type_q <= TYPE_IDLE;
            ds_q          <= 1'b0;
            cia_q         <= 32'h0000_0000;
            bad_q         <= 32'h0000_0000;
            flush_q       <= 1'b0;
            new_pc_q      <= 32'h0000_0000;
            exc_count_q   <= 16'h0000;
        end else begin
            state_q       <= state_d;
            cp0_en_q      <= cp0_en_d;
            except_type_q <= except_type_d;
            ds_q          <= ds_d;
            cia_q         <= cia_d;
            bad_q         <= bad_d;
            flush_q       <= flush_d;
            new_pc_q      <= new_pc_d;
            exc_count_q   <= exc_count_d;
        end
    end

    assign cp0_en            = cp0_en_q;
    assign except_type       = except_type_q;
    assign is_in_delayslot   = ds_q;
    assign current_inst_addr = cia_q;
    assign badvaddr_i        = bad_q;
    assign flush             = flush_q;
    assign new_pc            = new_pc_q;
    assign exc_count         = exc_count_q;
endmodule
